// File: rtl/seq_game_pkg.sv
// Shared types and constants for the memory-game sequencing controller.
package seq_game_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned LED_W  = 4;
    // Wide enough for the largest tick count (timeout default 250M < 2^28).
    localparam int unsigned TIMER_W = 28;

    localparam logic [ADDR_W-1:0] MAX_ROUND = 4'd15;
    localparam logic [LED_W-1:0]  LEDS_WIN  = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StShowOn,
        StShowOff,
        StWaitBtn,
        StCheck,
        StNext,
        StWin,
        StLose
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s inside {StIdle, StWin, StLose});
    endfunction

endpackage

// File: rtl/seq_tick_timer.sv
// Shared down-counter: load sets the count, done is high while the count is zero.
module seq_tick_timer
    import seq_game_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/seq_game_ctrl.sv
// Memory-game sequencer: plays ROM steps on the LEDs, then checks the player's presses.
module seq_game_ctrl
    import seq_game_pkg::*;
#(
    parameter int unsigned SHOW_TICKS    = 50_000_000,
    parameter int unsigned GAP_TICKS     = 25_000_000,
    parameter int unsigned TIMEOUT_TICKS = 250_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [LED_W-1:0]  i_btn,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [LED_W-1:0]  i_rom_data,
    output logic [LED_W-1:0]  o_leds,
    output logic [ADDR_W-1:0] o_round,
    output logic              o_busy,
    output logic              o_win,
    output logic              o_lose
);

    // Loading N-1 on state entry makes the state last exactly N cycles.
    localparam logic [TIMER_W-1:0] SHOW_LOAD    = TIMER_W'(SHOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_TICKS - 1);

    state_t              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_step, w_step_d;
    logic [ADDR_W-1:0]   r_round, w_round_d;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [LED_W-1:0]    r_leds, w_leds_d;
    logic [LED_W-1:0]    r_btn_prev;
    logic [LED_W-1:0]    r_btn_latch, w_btn_latch_d;
    logic                r_win, r_lose;
    logic                w_load;
    logic [TIMER_W-1:0]  w_load_val;
    logic                w_done;
    logic                w_press;

    seq_tick_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    assign w_press = (r_btn_prev == '0) && (i_btn != '0);

    always_comb begin
        w_state_d     = r_state;
        w_step_d      = r_step;
        w_round_d     = r_round;
        w_leds_d      = r_leds;
        w_btn_latch_d = r_btn_latch;
        w_load        = 1'b0;
        w_load_val    = '0;

        unique case (r_state)
            StIdle: begin
                w_leds_d = '0;
                if (i_start) begin
                    w_state_d  = StShowOn;
                    w_round_d  = '0;
                    w_step_d   = '0;
                    w_load     = 1'b1;
                    w_load_val = SHOW_LOAD;
                end
            end
            StShowOn: begin
                w_leds_d = i_rom_data;
                if (w_done) begin
                    w_state_d  = StShowOff;
                    w_load     = 1'b1;
                    w_load_val = GAP_LOAD;
                end
            end
            StShowOff: begin
                w_leds_d = '0;
                if (w_done) begin
                    w_load = 1'b1;
                    if (r_step < r_round) begin
                        w_step_d   = r_step + 1'b1;
                        w_state_d  = StShowOn;
                        w_load_val = SHOW_LOAD;
                    end else begin
                        w_step_d   = '0;
                        w_state_d  = StWaitBtn;
                        w_load_val = TIMEOUT_LOAD;
                    end
                end
            end
            StWaitBtn: begin
                // A press on the final timeout cycle still counts.
                if (w_press) begin
                    w_btn_latch_d = i_btn;
                    w_leds_d      = i_btn;
                    w_state_d     = StCheck;
                end else if (w_done) begin
                    w_state_d = StLose;
                end
            end
            StCheck: begin
                if (r_btn_latch != i_rom_data) begin
                    w_state_d = StLose;
                end else if (r_step < r_round) begin
                    w_step_d   = r_step + 1'b1;
                    w_state_d  = StWaitBtn;
                    w_load     = 1'b1;
                    w_load_val = TIMEOUT_LOAD;
                end else begin
                    w_state_d = StNext;
                end
            end
            StNext: begin
                w_leds_d = '0;
                if (r_round == MAX_ROUND) begin
                    w_state_d = StWin;
                end else begin
                    w_round_d  = r_round + 1'b1;
                    w_step_d   = '0;
                    w_state_d  = StShowOn;
                    w_load     = 1'b1;
                    w_load_val = SHOW_LOAD;
                end
            end
            StWin, StLose: begin
                w_leds_d = (r_state == StWin) ? LEDS_WIN : '0;
                if (i_start) begin
                    w_leds_d   = '0;
                    w_state_d  = StShowOn;
                    w_round_d  = '0;
                    w_step_d   = '0;
                    w_load     = 1'b1;
                    w_load_val = SHOW_LOAD;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_step      <= '0;
            r_round     <= '0;
            r_rom_addr  <= '0;
            r_leds      <= '0;
            r_btn_prev  <= '0;
            r_btn_latch <= '0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_step      <= w_step_d;
            r_round     <= w_round_d;
            // ROM address tracks the step, so it is valid on entry to SHOW_ON and CHECK.
            r_rom_addr  <= w_step_d;
            r_leds      <= w_leds_d;
            r_btn_prev  <= i_btn;
            r_btn_latch <= w_btn_latch_d;
            r_win       <= (r_state == StWin);
            r_lose      <= (r_state == StLose);
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_leds     = r_leds;
    assign o_round    = r_round;
    assign o_busy     = is_busy(r_state);
    assign o_win      = r_win;
    assign o_lose     = r_lose;

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Directed bench for seq_game_ctrl with a random one-hot ROM and a timing model.
module tb_seq_game_ctrl;

    localparam int S = 4;
    localparam int G = 2;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] leds;
    logic [3:0] round;
    logic       busy, win, lose;

    logic [3:0] rom [16];
    int checks = 0;
    int failures = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    seq_game_ctrl #(
        .SHOW_TICKS    (S),
        .GAP_TICKS     (G),
        .TIMEOUT_TICKS (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_btn      (btn),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_leds     (leds),
        .o_round    (round),
        .o_busy     (busy),
        .o_win      (win),
        .o_lose     (lose)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Called at a negedge; returns at the negedge observing SHOW_ON cycle 0.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Each step: dark on cycle 0, lit on cycles 1..S, dark until S+G-1.
    task automatic check_show(input int r, input bit poke_start);
        for (int k = 0; k <= r; k++) begin
            for (int o = 0; o < S + G; o++) begin
                check("show_leds", leds, (o >= 1 && o <= S) ? rom[k] : 4'b0);
                check("show_addr", rom_addr, k);
                check("show_busy", busy, 1);
                check("show_round", round, r);
                if (poke_start && k == 0) start = (o == 2);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    // Drive a one-cycle press, observe CHECK, return at the verdict cycle.
    task automatic press(input logic [3:0] v);
        btn = v;
        @(negedge clk);
        check("check_leds", leds, v);
        check("check_busy", busy, 1);
        btn = 4'b0;
        @(negedge clk);
    endtask

    task automatic play_round(input int r);
        check_show(r, 1'b0);
        for (int k = 0; k <= r; k++) begin
            press(rom[k]);
            check("verdict_busy", busy, 1);
            check("verdict_lose", lose, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 4'b0001;
        rom[1] = 4'b1000;
        rom[2] = 4'b0100;
        for (int i = 3; i < 16; i++) rom[i] = 4'b0001 << $urandom_range(0, 3);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_leds", leds, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_round", round, 0);
        check("rst_busy", busy, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);

        // Asynchronous reset in the middle of SHOW_ON.
        pulse_start();
        repeat (2) @(negedge clk);
        check("pre_rst_leds", leds, 4'b0001);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_leds", leds, 0);
        check("async_busy", busy, 0);
        check("async_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_leds", leds, 0);
        end

        // Round 0 correct, round 1 wrong second press.
        pulse_start();
        play_round(0);
        check_show(1, 1'b0);
        press(rom[0]);
        check("r1_mid_busy", busy, 1);
        press(4'b0100);
        check("wrong_busy", busy, 0);
        @(negedge clk);
        check("wrong_lose", lose, 1);
        check("wrong_leds", leds, 0);
        check("wrong_win", win, 0);

        // Timeout: no press for T cycles.
        pulse_start();
        check("restart_round", round, 0);
        check_show(0, 1'b0);
        for (int w = 0; w < T; w++) begin
            check("wait_busy", busy, 1);
            @(negedge clk);
        end
        check("timeout_busy", busy, 0);
        @(negedge clk);
        check("timeout_lose", lose, 1);

        // Press on the last allowed cycle is accepted.
        pulse_start();
        check_show(0, 1'b0);
        repeat (T - 1) @(negedge clk);
        press(rom[0]);
        check("late_busy", busy, 1);
        check("late_lose", lose, 0);
        @(negedge clk);
        check("late_round", round, 1);

        // Button held from playback is not a press; then a multi-bit press loses.
        btn = rom[0];
        check_show(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("held_leds", leds, 0);
            check("held_busy", busy, 1);
            @(negedge clk);
        end
        btn = 4'b0;
        @(negedge clk);
        press(rom[0]);
        check("held_step_busy", busy, 1);
        press(4'b0011);
        check("multi_busy", busy, 0);
        @(negedge clk);
        check("multi_lose", lose, 1);

        // Full game to WIN.
        pulse_start();
        for (int r = 0; r < 16; r++) play_round(r);
        check("win_busy0", busy, 0);
        check("win_round", round, 15);
        @(negedge clk);
        check("win_flag", win, 1);
        check("win_leds", leds, 4'b1111);
        check("win_busy", busy, 0);
        check("win_lose", lose, 0);

        // Restart from WIN; start pulses during playback are ignored.
        pulse_start();
        check("rewin_round", round, 0);
        check("rewin_busy", busy, 1);
        check_show(0, 1'b1);
        check("ignored_start_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
